// File: rtl/link_param_loader_pkg.sv
// Shared definitions for the link parameter loader: stage encoding, link word
// layout and loader state encoding.
package link_param_loader_pkg;

  localparam int MAX_WEIGHT     = 2;
  localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1);
  localparam int STAGE_WIDTH    = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;

  typedef struct packed {
    logic [LINK_BIT_WIDTH-1:0] weight;
    logic [1:0]                boundary;
  } link_param_t;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_READY  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } loader_state_t;

  function automatic logic is_param_loading(input logic [STAGE_WIDTH-1:0] stage);
    return stage == STAGE_PARAMETERS_LOADING;
  endfunction

endpackage

// File: rtl/link_param_buffer.sv
// Storage for one full set of link parameter words: sequential write port,
// sequential read port whose data is valid combinationally at rd_ptr.
module link_param_buffer
  import link_param_loader_pkg::*;
#(
  parameter  int NUM_LINKS = 64,
  localparam int PTR_W     = $clog2(NUM_LINKS),
  localparam int CNT_W     = $clog2(NUM_LINKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  link_param_t      wr_data,
  input  logic             rd_adv,
  output link_param_t      rd_data,
  output logic             rd_at_head,
  output logic [CNT_W-1:0] count
);

  link_param_t      mem [NUM_LINKS];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_LINKS - 1);

  // Pointer and fill-count next state; clear wins over any access.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (wr_en) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_adv) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Parameter storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data    = mem[rd_ptr_q];
  assign rd_at_head = (rd_ptr_q == {PTR_W{1'b0}});
  assign count      = count_q;

endmodule

// File: rtl/link_param_loader.sv
// Transmit end of the link parameter chain: buffers one set from the host and
// streams it into the chain head. Optional replay feature: LINK_PARAM_RELOAD_EN.
module link_param_loader
  import link_param_loader_pkg::*;
#(
  parameter int NUM_LINKS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [STAGE_WIDTH-1:0]    global_stage,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LINK_BIT_WIDTH-1:0] s_weight,
  input  logic [1:0]                s_boundary,
  input  logic                      reload_clear,
  output logic [LINK_BIT_WIDTH-1:0] weight_out,
  output logic [1:0]                boundary_condition_out,
  output logic                      load_req,
  output logic                      load_done,
  output logic                      load_error
);

  localparam int CNT_W = $clog2(NUM_LINKS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LINKS - 1);

  loader_state_t             state_q, state_d;
  logic                      s_ready_q, s_ready_d;
  logic [LINK_BIT_WIDTH-1:0] weight_q, weight_d;
  logic [1:0]                boundary_q, boundary_d;
  logic                      load_req_q, load_req_d;
  logic                      load_done_q, load_done_d;
  logic                      load_error_q, load_error_d;

  logic                      buf_clear_s, buf_wr_s, buf_adv_s;
  logic                      enter_fill_s, enter_ready_s;
  link_param_t               rd_data_s;
  logic                      rd_at_head_s;
  logic [CNT_W-1:0]          count_s;
  logic                      stage_load_s, accept_s;
  logic                      clear_req_s;

  assign stage_load_s = is_param_loading(global_stage);
  assign accept_s     = s_valid && s_ready_q;

`ifdef LINK_PARAM_RELOAD_EN
  assign clear_req_s = reload_clear;
`else
  logic reload_clear_unused;
  assign reload_clear_unused = reload_clear;
  assign clear_req_s         = 1'b0;
`endif

  link_param_buffer #(.NUM_LINKS(NUM_LINKS)) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .clear      (buf_clear_s),
    .wr_en      (buf_wr_s),
    .wr_data    ('{weight: s_weight, boundary: s_boundary}),
    .rd_adv     (buf_adv_s),
    .rd_data    (rd_data_s),
    .rd_at_head (rd_at_head_s),
    .count      (count_s)
  );

  // Loader FSM next state. The read pointer always sits one entry ahead of the
  // presented word, so it wraps to the head exactly when the last entry is shown.
  always_comb begin
    state_d       = state_q;
    s_ready_d     = s_ready_q;
    weight_d      = weight_q;
    boundary_d    = boundary_q;
    load_req_d    = load_req_q;
    load_done_d   = load_done_q;
    load_error_d  = load_error_q;
    buf_clear_s   = 1'b0;
    buf_wr_s      = 1'b0;
    buf_adv_s     = 1'b0;
    enter_fill_s  = 1'b0;
    enter_ready_s = 1'b0;
    case (state_q)
      ST_FILL: begin
        s_ready_d   = 1'b1;
        weight_d    = {LINK_BIT_WIDTH{1'b0}};
        boundary_d  = 2'b00;
        load_req_d  = 1'b0;
        load_done_d = 1'b0;
        if (accept_s) begin
          buf_wr_s = 1'b1;
          if (count_s == {CNT_W{1'b0}}) begin
            load_error_d = 1'b0;
          end else begin
            load_error_d = load_error_q;
          end
          if (count_s == LAST_CNT) begin
            enter_ready_s = 1'b1;
          end else begin
            enter_ready_s = 1'b0;
          end
        end else begin
          buf_wr_s = 1'b0;
        end
        if (stage_load_s) begin
          load_error_d = 1'b1;
        end else begin
          load_error_d = load_error_d;
        end
      end
      ST_READY: begin
        if (clear_req_s) begin
          enter_fill_s = 1'b1;
        end else if (stage_load_s) begin
          state_d    = ST_STREAM;
          load_req_d = 1'b0;
          weight_d   = rd_data_s.weight;
          boundary_d = rd_data_s.boundary;
          buf_adv_s  = 1'b1;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_STREAM: begin
        if (stage_load_s) begin
          if (rd_at_head_s) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            weight_d    = {LINK_BIT_WIDTH{1'b0}};
            boundary_d  = 2'b00;
          end else begin
            weight_d   = rd_data_s.weight;
            boundary_d = rd_data_s.boundary;
            buf_adv_s  = 1'b1;
          end
        end else begin
          load_error_d = 1'b1;
          enter_fill_s = 1'b1;
        end
      end
      ST_DONE: begin
        if (clear_req_s) begin
          enter_fill_s = 1'b1;
        end else if (stage_load_s) begin
          load_error_d = 1'b1;
        end else begin
`ifdef LINK_PARAM_RELOAD_EN
          enter_ready_s = 1'b1;
`else
          enter_fill_s  = 1'b1;
`endif
        end
      end
      default: begin
        enter_fill_s = 1'b1;
      end
    endcase

    if (enter_fill_s) begin
      state_d     = ST_FILL;
      s_ready_d   = 1'b1;
      weight_d    = {LINK_BIT_WIDTH{1'b0}};
      boundary_d  = 2'b00;
      load_req_d  = 1'b0;
      load_done_d = 1'b0;
      buf_clear_s = 1'b1;
    end else if (enter_ready_s) begin
      // Read pointer is at the head here, so the preload is entry 0.
      state_d     = ST_READY;
      s_ready_d   = 1'b0;
      weight_d    = rd_data_s.weight;
      boundary_d  = rd_data_s.boundary;
      load_req_d  = 1'b1;
      load_done_d = 1'b0;
      buf_adv_s   = 1'b1;
    end else begin
      buf_clear_s = 1'b0;
    end
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_FILL;
      s_ready_q    <= 1'b0;
      weight_q     <= {LINK_BIT_WIDTH{1'b0}};
      boundary_q   <= 2'b00;
      load_req_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      weight_q     <= weight_d;
      boundary_q   <= boundary_d;
      load_req_q   <= load_req_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign s_ready                = s_ready_q;
  assign weight_out             = weight_q;
  assign boundary_condition_out = boundary_q;
  assign load_req               = load_req_q;
  assign load_done              = load_done_q;
  assign load_error             = load_error_q;

endmodule

// File: tb/tb_link_param_loader.sv
// Directed self-checking bench for link_param_loader with NUM_LINKS=4.
// Replay scenario runs only when LINK_PARAM_RELOAD_EN is defined.
module tb_link_param_loader;
  import link_param_loader_pkg::*;

  logic                      clk;
  logic                      reset;
  logic [STAGE_WIDTH-1:0]    global_stage;
  logic                      s_valid;
  logic                      s_ready;
  logic [LINK_BIT_WIDTH-1:0] s_weight;
  logic [1:0]                s_boundary;
  logic                      reload_clear;
  logic [LINK_BIT_WIDTH-1:0] weight_out;
  logic [1:0]                boundary_condition_out;
  logic                      load_req;
  logic                      load_done;
  logic                      load_error;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_w [4];
  logic [1:0] exp_b [4];

  link_param_loader #(.NUM_LINKS(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .global_stage           (global_stage),
    .s_valid                (s_valid),
    .s_ready                (s_ready),
    .s_weight               (s_weight),
    .s_boundary             (s_boundary),
    .reload_clear           (reload_clear),
    .weight_out             (weight_out),
    .boundary_condition_out (boundary_condition_out),
    .load_req               (load_req),
    .load_done              (load_done),
    .load_error             (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [7:0] ws, input logic [7:0] bs);
    for (int i = 0; i < 4; i++) begin
      exp_w[i] = ws[7-2*i -: 2];
      exp_b[i] = bs[7-2*i -: 2];
    end
  endtask

  task automatic push_word(input int i);
    s_valid    = 1'b1;
    s_weight   = exp_w[i];
    s_boundary = exp_b[i];
    tick();
    s_valid    = 1'b0;
  endtask

  task automatic run_stage(input int len, input string tag);
    logic [1:0] ew, eb;
    global_stage = STAGE_PARAMETERS_LOADING;
    for (int k = 0; k < len; k++) begin
      ew = (k < 4) ? exp_w[k] : 2'd0;
      eb = (k < 4) ? exp_b[k] : 2'd0;
      checks++;
      if (weight_out !== ew || boundary_condition_out !== eb) begin
        errors++;
        $display("FAIL %s cycle %0d: got w=%0d b=%0d, expected w=%0d b=%0d",
                 tag, k, weight_out, boundary_condition_out, ew, eb);
      end
      tick();
    end
    global_stage = STAGE_IDLE;
  endtask

  // Leave DONE and end up back in FILL in either build.
  task automatic finish_done(input string tag);
    tick();
`ifdef LINK_PARAM_RELOAD_EN
    checks++;
    if (load_req !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s replay_ready: got req=%0b rdy=%0b, expected 1 0", tag, load_req, s_ready);
    end
    reload_clear = 1'b1;
    tick();
    reload_clear = 1'b0;
`endif
    checks++;
    if (s_ready !== 1'b1 || load_done !== 1'b0 || load_req !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_fill: got rdy=%0b done=%0b req=%0b, expected 1 0 0",
               tag, s_ready, load_done, load_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; global_stage = STAGE_IDLE; s_valid = 1'b0;
    s_weight = 2'd0; s_boundary = 2'd0; reload_clear = 1'b0;
    tick(); tick();
    checks++;
    if ({s_ready, weight_out, boundary_condition_out, load_req, load_done, load_error} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {s_ready, weight_out, boundary_condition_out, load_req, load_done, load_error});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b, expected 1", s_ready);
    end
  endtask

  task automatic test_basic_stream();
    set_words({2'd2, 2'd1, 2'd2, 2'd0}, {2'd0, 2'd1, 2'd2, 2'd0});
    for (int i = 0; i < 4; i++) push_word(i);
    checks++;
    if (load_req !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready: got req=%0b rdy=%0b, expected 1 0", load_req, s_ready);
    end
    run_stage(4, "basic_stream");
    checks++;
    if (load_done !== 1'b1 || load_error !== 1'b0 || weight_out !== 2'd0 || boundary_condition_out !== 2'd0) begin
      errors++;
      $display("FAIL basic_done: got done=%0b err=%0b w=%0d b=%0d, expected 1 0 0 0",
               load_done, load_error, weight_out, boundary_condition_out);
    end
    finish_done("basic");
  endtask

  task automatic test_valid_toggle();
    set_words({2'd0, 2'd2, 2'd1, 2'd1}, {2'd2, 2'd1, 2'd0, 2'd2});
    for (int i = 0; i < 8; i++) begin
      s_valid    = (i % 2 == 0);
      s_weight   = exp_w[i/2];
      s_boundary = exp_b[i/2];
      tick();
      checks++;
      if (s_ready !== ((i >= 6) ? 1'b0 : 1'b1) || load_req !== ((i >= 6) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL toggle_handshake step %0d: got rdy=%0b req=%0b", i, s_ready, load_req);
      end
    end
    s_valid = 1'b1; s_weight = 2'd1; s_boundary = 2'd1;
    tick(); tick();
    s_valid = 1'b0;
    run_stage(4, "toggle_stream");
    finish_done("toggle");
  endtask

  task automatic test_short_stage();
    set_words({2'd1, 2'd2, 2'd0, 2'd2}, {2'd1, 2'd0, 2'd2, 2'd1});
    for (int i = 0; i < 4; i++) push_word(i);
    run_stage(2, "short_stream");
    tick();
    checks++;
    if (load_error !== 1'b1 || s_ready !== 1'b1 || load_req !== 1'b0 || weight_out !== 2'd0) begin
      errors++;
      $display("FAIL short_abort: got err=%0b rdy=%0b req=%0b w=%0d, expected 1 1 0 0",
               load_error, s_ready, load_req, weight_out);
    end
    push_word(0);
    checks++;
    if (load_error !== 1'b0) begin
      errors++;
      $display("FAIL short_err_clear: got %0b, expected 0", load_error);
    end
    for (int i = 1; i < 4; i++) push_word(i);
    checks++;
    if (load_req !== 1'b1) begin
      errors++;
      $display("FAIL short_refill_req: got %0b, expected 1", load_req);
    end
  endtask

  task automatic test_long_stage();
    run_stage(6, "long_stream");
    checks++;
    if (load_error !== 1'b1 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL long_error: got err=%0b done=%0b, expected 1 1", load_error, load_done);
    end
    finish_done("long");
    checks++;
    if (load_error !== 1'b1) begin
      errors++;
      $display("FAIL long_err_sticky: got %0b, expected 1", load_error);
    end
  endtask

  task automatic test_reset_midstream();
    set_words({2'd2, 2'd0, 2'd1, 2'd2}, {2'd2, 2'd1, 2'd1, 2'd0});
    for (int i = 0; i < 4; i++) push_word(i);
    global_stage = STAGE_PARAMETERS_LOADING;
    tick();
    checks++;
    if (weight_out !== exp_w[1] || boundary_condition_out !== exp_b[1]) begin
      errors++;
      $display("FAIL midreset_cycle1: got w=%0d b=%0d, expected w=%0d b=%0d",
               weight_out, boundary_condition_out, exp_w[1], exp_b[1]);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({s_ready, weight_out, boundary_condition_out, load_req, load_done, load_error} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got %b, expected 00000000",
               {s_ready, weight_out, boundary_condition_out, load_req, load_done, load_error});
    end
    reset = 1'b1;
    global_stage = STAGE_IDLE;
    tick();
    checks++;
    if (s_ready !== 1'b1 || load_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got rdy=%0b req=%0b, expected 1 0", s_ready, load_req);
    end
    set_words({2'd1, 2'd0, 2'd2, 2'd1}, {2'd0, 2'd2, 2'd1, 2'd1});
    for (int i = 0; i < 3; i++) push_word(i);
    checks++;
    if (load_req !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_count: got req=%0b rdy=%0b after 3 words, expected 0 1", load_req, s_ready);
    end
    push_word(3);
    checks++;
    if (load_req !== 1'b1) begin
      errors++;
      $display("FAIL midreset_full: got req=%0b, expected 1", load_req);
    end
  endtask

  task automatic test_back_to_back();
    run_stage(4, "b2b_first");
`ifdef LINK_PARAM_RELOAD_EN
    tick();
    checks++;
    if (load_req !== 1'b1 || load_done !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_ready: got req=%0b done=%0b rdy=%0b, expected 1 0 0",
               load_req, load_done, s_ready);
    end
    run_stage(4, "b2b_replay");
    tick();
    reload_clear = 1'b1;
    tick();
    reload_clear = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || load_req !== 1'b0) begin
      errors++;
      $display("FAIL reload_clear: got rdy=%0b req=%0b, expected 1 0", s_ready, load_req);
    end
`else
    finish_done("b2b");
`endif
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_valid_toggle();
    test_short_stage();
    test_long_stage();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
